// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one Keccak-f[1600] core between NUM_REQ sponge requesters.
// Define KECCAK_ARB_LOCK_EN to let a requester keep priority across back-to-back permutations.
module keccak_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned STATE_W = 1600,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*STATE_W-1:0] req_state,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [STATE_W-1:0]         rsp_state,
    output logic                       rsp_err,
    output logic                       perm_start,
    output logic [STATE_W-1:0]         perm_state_in,
    input  logic                       perm_done,
    input  logic [STATE_W-1:0]         perm_state_out,
    output logic                       busy,
    output logic                       err_sticky
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [STATE_W-1:0]   st_q, st_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic                 perm_start_q, perm_start_d;
    logic                 busy_q, busy_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [SUM_W-1:0]     sum;
    logic [IDX_W-1:0]     ptr_adv;

`ifndef KECCAK_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            if (!sel_found && req_valid[sum[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sum[IDX_W-1:0];
            end
        end
    end

    assign ptr_adv = (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        st_d         = st_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        err_sticky_d = err_sticky_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    gnt_d              = sel_idx;
                    st_d               = req_state[STATE_W * 32'(sel_idx) +: STATE_W];
                    state_d            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done pulse on the final count still counts as success.
                if (perm_done) begin
                    st_d               = perm_state_out;
                    rsp_err_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = S_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    st_d               = '0;
                    rsp_err_d          = 1'b1;
                    err_sticky_d       = 1'b1;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    rsp_err_d   = 1'b0;
`ifdef KECCAK_ARB_LOCK_EN
                    ptr_d       = req_lock[gnt_q] ? gnt_q : ptr_adv;
`else
                    ptr_d       = ptr_adv;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        perm_start_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            ptr_q        <= '0;
            st_q         <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            perm_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
            perm_start_q <= perm_start_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_state     = st_q;
    assign rsp_err       = rsp_err_q;
    assign perm_start    = perm_start_q;
    assign perm_state_in = st_q;
    assign busy          = busy_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Scoreboard bench for keccak_arbiter with a 24-cycle stub core returning the inverted state.
module tb_keccak_arbiter;

    localparam int NR = 3;
    localparam int SW = 1600;
    localparam int L  = 24;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*SW-1:0] req_state;
    logic [NR-1:0]   req_lock;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [SW-1:0]   rsp_state;
    logic            rsp_err;
    logic            perm_start;
    logic [SW-1:0]   perm_state_in;
    logic            perm_done;
    logic [SW-1:0]   perm_state_out;
    logic            busy;
    logic            err_sticky;

    keccak_arbiter #(.NUM_REQ(NR), .STATE_W(SW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_state(req_state), .req_lock(req_lock),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_state(rsp_state), .rsp_err(rsp_err),
        .perm_start(perm_start), .perm_state_in(perm_state_in),
        .perm_done(perm_done), .perm_state_out(perm_state_out),
        .busy(busy), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done pulse L cycles after start, result is the inverted input.
    logic          stub_en;
    logic          stub_done = 1'b0;
    logic          manual_done;
    logic [SW-1:0] stub_buf = '0;
    int            stub_cnt = 0;
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (perm_start) begin
            stub_cnt <= 1;
            stub_buf <= ~perm_state_in;
        end else if (stub_cnt != 0) begin
            if (stub_cnt == L - 1) begin
                stub_done <= stub_en;
                stub_cnt  <= 0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end
    assign perm_done      = stub_done | manual_done;
    assign perm_state_out = stub_buf;

    typedef struct {
        int            idx;
        logic [SW-1:0] st;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic int idx_of(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_state(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got low64 %0h expected low64 %0h (cycle %0d)", name, act[63:0], exp[63:0], cyc);
        end
    endtask

    task automatic push(input int idx, input logic [SW-1:0] st, input logic err);
        exp_t e;
        e.idx = idx;
        e.st  = st;
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Monitor: every response handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (!reset && (rsp_valid & rsp_ready) != '0) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_valid_onehot", 64'(rsp_valid), 64'(oh(e.idx)));
                check_state("rsp_state", rsp_state, e.st);
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic set_state(input int i, input logic [SW-1:0] v);
        req_state[i*SW +: SW] = v;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_accept(output int idx, output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == '0) check("accept_timeout", 64'(0), 64'(1));
        idx = idx_of(req_ready);
        c   = cyc;
    endtask

    task automatic wait_rsp(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid == '0) check("rsp_timeout", 64'(0), 64'(1));
        c = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check("idle_reached", 64'(busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int idx, t, c, hs;
        int order[4];
        logic [SW-1:0] s0, s1, s2;

        reset = 1'b1; req_valid = '0; req_state = '0; req_lock = '0;
        rsp_ready = '0; stub_en = 1'b1; manual_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_perm_start", 64'(perm_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err_sticky", 64'(err_sticky), 64'(0));
        check_state("rst_perm_state_in", perm_state_in, '0);

        // Single request on requester 0.
        rsp_ready = 3'b111;
        @(posedge clk); #1;
        s0 = 1600'h5;
        set_state(0, s0);
        req_valid = 3'b001;
        push(0, ~s0, 1'b0);
        wait_accept(idx, t);
        check("t1_grant", 64'(idx), 64'(0));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("t1_perm_start_hi", 64'(perm_start), 64'(1));
        check_state("t1_perm_state_in", perm_state_in, s0);
        @(negedge clk);
        check("t1_perm_start_lo", 64'(perm_start), 64'(0));
        check("t1_busy", 64'(busy), 64'(1));
        wait_rsp(c);
        check("t1_rsp_latency", 64'(c - t), 64'(26));
        wait_idle();

        // All three valid continuously: grant order 0,1,2,0 every 27 cycles.
        do_reset();
        @(posedge clk); #1;
        s0 = 1600'h1; s1 = 1600'h2; s2 = 1600'h3;
        set_state(0, s0); set_state(1, s1); set_state(2, s2);
        req_valid = 3'b111;
        order = '{0, 1, 2, 0};
        push(0, ~s0, 1'b0); push(1, ~s1, 1'b0); push(2, ~s2, 1'b0); push(0, ~s0, 1'b0);
        t = 0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(idx, c);
            check("t2_grant", 64'(idx), 64'(order[k]));
            if (k > 0) check("t2_spacing", 64'(c - t), 64'(27));
            t = c;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        // Core never completes: timeout abort on requester 1.
        stub_en = 1'b0;
        @(posedge clk); #1;
        set_state(1, 1600'h7);
        req_valid = 3'b010;
        push(1, '0, 1'b1);
        wait_accept(idx, t);
        check("t3_grant", 64'(idx), 64'(1));
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(c);
        check("t3_timeout_latency", 64'(c - t), 64'(66));
        check("t3_rsp_err", 64'(rsp_err), 64'(1));
        check("t3_err_sticky", 64'(err_sticky), 64'(1));
        wait_idle();
        stub_en = 1'b1;
        @(posedge clk); #1;
        s2 = 1600'h9;
        set_state(2, s2);
        req_valid = 3'b100;
        push(2, ~s2, 1'b0);
        wait_accept(idx, t);
        check("t3b_grant", 64'(idx), 64'(2));
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(c);
        check("t3b_latency", 64'(c - t), 64'(26));
        check("t3b_err_sticky_held", 64'(err_sticky), 64'(1));
        wait_idle();
        do_reset();
        @(negedge clk);
        check("t3_err_sticky_cleared", 64'(err_sticky), 64'(0));

        // Reset during WAIT, then a stray done pulse.
        stub_en = 1'b0;
        @(posedge clk); #1;
        set_state(0, 1600'h11);
        req_valid = 3'b001;
        wait_accept(idx, t);
        check("t4_grant", 64'(idx), 64'(0));
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(negedge clk);
        check("t4_busy_in_wait", 64'(busy), 64'(1));
        do_reset();
        @(posedge clk);
        @(posedge clk); #1 manual_done = 1'b1;
        @(posedge clk); #1 manual_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_rsp_valid", 64'(rsp_valid), 64'(0));
            check("t4_busy", 64'(busy), 64'(0));
            check("t4_perm_start", 64'(perm_start), 64'(0));
            check("t4_rsp_err", 64'(rsp_err), 64'(0));
            check_state("t4_perm_state_in", perm_state_in, '0);
        end
        stub_en = 1'b1;

        // Response back-pressure: held 10 cycles, no new accept meanwhile.
        rsp_ready = 3'b000;
        @(posedge clk); #1;
        s0 = 1600'hA5; s1 = 1600'h3C;
        set_state(0, s0); set_state(1, s1);
        req_valid = 3'b011;
        push(0, ~s0, 1'b0);
        wait_accept(idx, t);
        check("t5_grant", 64'(idx), 64'(0));
        @(posedge clk); #1 req_valid = 3'b010;
        wait_rsp(c);
        check("t5_latency", 64'(c - t), 64'(26));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("t5_hold_valid", 64'(rsp_valid), 64'(3'b001));
            check_state("t5_hold_state", rsp_state, ~s0);
            check("t5_no_accept", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1 rsp_ready = 3'b001;
        push(1, ~s1, 1'b0);
        @(negedge clk);
        hs = cyc;
        wait_accept(idx, c);
        check("t5_next_grant", 64'(idx), 64'(1));
        check("t5_next_accept_cycle", 64'(c - hs), 64'(1));
        @(posedge clk); #1 req_valid = '0; rsp_ready = 3'b111;
        wait_idle();

        // Lock behaviour starting from ptr=1.
        do_reset();
        @(posedge clk); #1;
        set_state(0, 1600'h55);
        req_valid = 3'b001;
        push(0, ~(SW'(1600'h55)), 1'b0);
        wait_accept(idx, t);
        check("t6_setup_grant", 64'(idx), 64'(0));
        @(posedge clk); #1 req_valid = '0;
        wait_idle();
`ifdef KECCAK_ARB_LOCK_EN
        order = '{1, 1, 1, 2};
`else
        order = '{1, 2, 0, 1};
`endif
        @(posedge clk); #1;
        s0 = 1600'h100; s1 = 1600'h101; s2 = 1600'h102;
        set_state(0, s0); set_state(1, s1); set_state(2, s2);
        req_lock  = 3'b010;
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            case (order[k])
                0:       push(0, ~s0, 1'b0);
                1:       push(1, ~s1, 1'b0);
                default: push(2, ~s2, 1'b0);
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            wait_accept(idx, c);
            check("t6_grant", 64'(idx), 64'(order[k]));
            if (k == 2) begin
                @(posedge clk); #1 req_lock = '0;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        wait_idle();
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
